// File: rtl/write_channels_resp_if.sv
// Write-channel bundle between a manager and the responder (aw/w/b) plus
// the responder's line-write port toward the DRAM-side store.
interface write_channels_resp_if #(
    parameter int BEATS   = 4,
    parameter int LADDR_W = 28
);
    logic                  awvalid;
    logic                  awready;
    logic [3:0]            awid;
    logic [31:0]           awaddr;
    logic [5:0]            awatop;

    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [3:0]            bid;
    logic                  bcomp;

    logic                  lw_valid;
    logic                  lw_ready;
    logic [LADDR_W-1:0]    lw_addr;
    logic [32*BEATS-1:0]   lw_data;

    modport slave (
        input  awvalid, awid, awaddr, awatop,
        input  wvalid, wdata, wlast,
        input  bready,
        input  lw_ready,
        output awready, wready, bvalid, bid, bcomp,
        output lw_valid, lw_addr, lw_data
    );

    modport master (
        output awvalid, awid, awaddr, awatop,
        output wvalid, wdata, wlast,
        output bready,
        output lw_ready,
        input  awready, wready, bvalid, bid, bcomp,
        input  lw_valid, lw_addr, lw_data
    );
endinterface

// File: rtl/write_channels_resp.sv
// Write-channel responder: takes one aw handshake and a BEATS x 32-bit burst,
// writes the assembled line, then answers on b with the captured id.
module write_channels_resp #(
    parameter int BEATS   = 4,
    parameter int LADDR_W = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    write_channels_resp_if.slave bus
);
    localparam int               CNT_W    = $clog2(BEATS + 1);
    localparam int               IDX_W    = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(BEATS);

    typedef enum logic [1:0] {IDLE, DATA, LINE, RESP} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              id_q;
    logic [LADDR_W-1:0]      addr_q;
    logic                    err_q;
    logic [CNT_W-1:0]        beat_cnt;
    logic [BEATS-1:0][31:0]  line_q;

    logic aw_hs;
    logic w_hs;
    logic lw_hs;
    logic b_hs;
    logic wlast_bad;
    logic unused_addr_bits;

    // Readies/valids come straight from the state, so each handshake only
    // needs the peer's side qualified here.
    assign aw_hs     = (state == IDLE) && bus.awvalid;
    assign w_hs      = (state == DATA) && bus.wvalid;
    assign lw_hs     = (state == LINE) && bus.lw_ready;
    assign b_hs      = (state == RESP) && bus.bready;
    assign wlast_bad = (beat_cnt != LAST_IDX);

    assign unused_addr_bits = ^bus.awaddr[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt
        // unassigned, which would infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE: if (aw_hs) state_nxt = DATA;
            DATA: if (w_hs && bus.wlast) state_nxt = (err_q || wlast_bad) ? RESP : LINE;
            LINE: if (lw_hs) state_nxt = RESP;
            RESP: if (b_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q     <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            beat_cnt <= '0;
            // NOTE: the line register is reset because lw_data must read
            // zero out of reset; plain storage arrays elsewhere would not be.
            line_q   <= '0;
        end else if (aw_hs) begin
            id_q     <= bus.awid;
            addr_q   <= bus.awaddr[LADDR_W+3:4];
            err_q    <= |bus.awatop;
            beat_cnt <= '0;
            line_q   <= '0;
        end else if (w_hs) begin
            // Beats past the line width are drained without being stored.
            if (beat_cnt != MAX_CNT) begin
                line_q[beat_cnt[IDX_W-1:0]] <= bus.wdata;
                beat_cnt                    <= beat_cnt + CNT_W'(1);
            end
            if (bus.wlast && wlast_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.awready  = (state == IDLE);
    assign bus.wready   = (state == DATA);
    assign bus.lw_valid = (state == LINE);
    assign bus.bvalid   = (state == RESP);
    assign bus.bcomp    = (state == RESP) && !err_q;
    assign bus.bid      = id_q;
    assign bus.lw_addr  = addr_q;
    assign bus.lw_data  = line_q;
endmodule

// File: doc/write_channels_resp.md
# write_channels_resp

Responder (slave) end of the team's AXI-style write channels. It accepts one address (aw) handshake and a 4-beat, 32-bit data burst (w), and assembles the beats into a 128-bit line. It issues the line on a local line-write port toward the DRAM-side store, then returns a write response (b) carrying the captured id. It is the counterpart of `write_channels_mngr` and sits in front of the memory-side logic in place of a full `dram_top` write path.

## Interface
Parameters:
- `BEATS`, 4: data beats per burst; `BEATS` × 32 = line width 128.
- `LADDR_W`, 28: width of the line address, taken as `awaddr[LADDR_W+3:4]`.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `awvalid`, input, 1: address valid.
- `awready`, output, 1: address ready.
- `awid`, input, 4: transaction id.
- `awaddr`, input, 32: byte address; bits [3:0] are ignored (line aligned).
- `awatop`, input, 6: atomic op code; non-zero is unsupported.
- `wvalid`, input, 1: data beat valid.
- `wready`, output, 1: data beat ready.
- `wdata`, input, 32: data beat.
- `wlast`, input, 1: last beat of the burst.
- `bvalid`, output, 1: response valid.
- `bready`, input, 1: response ready.
- `bid`, output, 4: response id, equal to the captured `awid`.
- `bcomp`, output, 1: 1 = write completed; 0 = error, line not written.
- `lw_valid`, output, 1: line write request.
- `lw_ready`, input, 1: line write accepted.
- `lw_addr`, output, `LADDR_W`: line address.
- `lw_data`, output, 128: assembled line.

## Operation
The FSM has four states: IDLE, DATA, LINE, RESP. Outputs are registered and decoded from the state.
- **IDLE:** `awready`=1. On `awvalid & awready`, capture `awid`, `awaddr[LADDR_W+3:4]` and `err = (awatop != 0)`; clear `beat_cnt` and the `lw_data` assembly register; go to DATA.
- **DATA:** `wready`=1. Each `wvalid & wready` stores `wdata` into `lw_data[32*beat_cnt +: 32]`; beat 0 fills bits [31:0].
  - `beat_cnt` is 3 bits and saturates at `BEATS`. Beats after the 4th are discarded.
  - On the accepted beat with `wlast`=1: set `err` if that was not exactly the 4th beat.
  - Then go to LINE if `err`=0, otherwise go to RESP.
  - Without `wlast`, stay in DATA indefinitely; the responder drains until `wlast`.
- **LINE:** `lw_valid`=1, with `lw_addr` and `lw_data` stable. On `lw_valid & lw_ready`, go to RESP.
- **RESP:** `bvalid`=1, `bid`=captured id, `bcomp`=~`err`. On `bvalid & bready`, go to IDLE.
- Only one transaction is in flight. `awready`=0 outside IDLE and `wready`=0 outside DATA.
- Beats presented while in IDLE are not accepted (`wready`=0); they wait.

## Timing
- **Reset values:** state=IDLE, so `awready`=1. `wready`, `lw_valid`, `bvalid` and `bcomp` are 0. `bid`, `lw_addr` and `lw_data` are all zeros.
- **Asynchronous reset mid-transaction** returns immediately to IDLE with the values above. The partial line is discarded, no `lw_valid` pulse is issued, and no response is sent.
- **Minimum latency** (all valids/readies high), with the aw handshake at cycle 0:
  - `wready` is high on cycles 1–4 and the beats are accepted there.
  - `lw_valid` is high on cycle 5 and accepted at cycle 5.
  - `bvalid` is high on cycle 6 and accepted at cycle 6.
  - `awready` is high again on cycle 7.
  - A new aw handshake can occur at cycle 7, giving 7 cycles per transaction.
- **Error path:** `bvalid` is asserted the cycle after the `wlast` beat; there is no LINE state.
- **Stalls:** a low `wvalid`, `lw_ready` or `bready` holds the current state. All outputs stay stable while valid is high and ready is low.
- Handshakes complete on the clock edge where valid & ready are both 1. Valid/ready are never combinationally dependent on the peer.

## Test plan
- **Normal write:** aw id=5, addr=0xdeadbeef, atop=0; beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 with wlast on the 4th; `lw_ready`=`bready`=1.
  - Required: `lw_valid` for one cycle, `lw_addr`=0xdeadbee, `lw_data`=0x44444444_33333333_22222222_11111111.
  - Then `bvalid` with bid=5, bcomp=1. Total 7 cycles.
- **Backpressure:** same transfer with `wvalid` gapped every other cycle, `lw_ready` low for 3 cycles and `bready` low for 2 cycles.
  - Required: identical line and response; outputs stable during every stall; `awready`=0 until `bvalid & bready`.
- **Short burst:** `wlast` on the 2nd beat.
  - Required: no `lw_valid`; `bvalid` the next cycle with bcomp=0 and bid equal to the captured id.
- **Long burst and atomic:**
  - 6 beats with `wlast` on the 6th: 6 beats accepted, bcomp=0, no line write.
  - `awatop`=0x01 with a normal 4-beat burst: bcomp=0, no line write.
- **Reset mid-burst:** assert `rst_n` low after the 2nd beat, then release and run the normal write with id=3.
  - Required: no response for the aborted transfer; the second transfer completes with bid=3, bcomp=1, and only the new data in `lw_data`.
- **Back-to-back:** two normal writes with `awvalid` held high. The 2nd aw is accepted on the cycle after the 1st b handshake, and the ids are returned in order.
